// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types for the decode-side hazard/forwarding scoreboard.
package pipeline_scoreboard_pkg;
  localparam int RD_W = 5;
  localparam int SEL_REGFILE = 0;
  localparam logic [RD_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            load;
  } slot_t;
endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue info, operand lookup, bypass results, perf counters.
interface pipeline_scoreboard_if #(
  parameter int NUM_READ = 2,
  parameter int DEPTH    = 3,
  parameter int REG_BITS = 5,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                         issue_valid;
  logic                         issue_we;
  logic                         issue_load;
  logic [REG_BITS-1:0]          issue_rd;
  logic                         flush;
  logic [NUM_READ*REG_BITS-1:0] rs_index;
  logic [NUM_READ*DATA_W-1:0]   rf_rdata;
  logic [DEPTH*DATA_W-1:0]      stage_wdata;
  logic [NUM_READ*DATA_W-1:0]   fwd_data;
  logic [NUM_READ*SEL_W-1:0]    fwd_sel;
  logic                         stall;
  logic [CNT_W-1:0]             stall_cnt;
  logic [CNT_W-1:0]             fwd_cnt;

  modport master (
    output issue_valid, issue_we, issue_load, issue_rd, flush, rs_index, rf_rdata, stage_wdata,
    input  fwd_data, fwd_sel, stall, stall_cnt, fwd_cnt
  );
  modport slave (
    input  issue_valid, issue_we, issue_load, issue_rd, flush, rs_index, rf_rdata, stage_wdata,
    output fwd_data, fwd_sel, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/pipeline_scoreboard_lookup.sv
// One read port: youngest matching in-flight producer wins; early load results raise a hazard.
module pipeline_scoreboard_lookup
  import pipeline_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 32,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic [RD_W-1:0]              rs,
  input  slot_t [DEPTH-1:0]            slots,
  input  logic [DEPTH-1:0][DATA_W-1:0] stage_wdata,
  input  logic [DATA_W-1:0]            rf_rdata,
  output logic [DATA_W-1:0]            data,
  output logic [SEL_W-1:0]             sel,
  output logic                         hazard
);
  logic found;

  always_comb begin
    data   = rf_rdata;
    sel    = SEL_W'(SEL_REGFILE);
    hazard = 1'b0;
    found  = 1'b0;
    if (rs != REG_ZERO) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && slots[i].valid && slots[i].rd == rs) begin
          found = 1'b1;
          // Load data not yet on this stage's result bus: must wait.
          if (slots[i].load && i < LOAD_READY) hazard = 1'b1;
          else begin
            sel  = SEL_W'(i + 1);
            data = stage_wdata[i];
          end
        end
      end
    end
  end
endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding unit: in-flight write shift register, per-port lookup, stall and perf counters.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int NUM_READ   = 2,
  parameter int DEPTH      = 3,
  parameter int REG_BITS   = RD_W,
  parameter int DATA_W     = 32,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_scoreboard_if.slave sb
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  slot_t [DEPTH-1:0]                 slots;
  logic [DEPTH-1:0][DATA_W-1:0]      stage_wdata;
  logic [NUM_READ-1:0][DATA_W-1:0]   fwd_data_a;
  logic [NUM_READ-1:0][SEL_W-1:0]    fwd_sel_a;
  logic [NUM_READ-1:0]               hazard;
  logic                              stall;
  logic                              enter;
  logic                              any_fwd;

  assign stage_wdata = sb.stage_wdata;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    pipeline_scoreboard_lookup #(
      .DEPTH(DEPTH), .DATA_W(DATA_W), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
    ) u_lookup (
      .rs          (sb.rs_index[p*REG_BITS +: REG_BITS]),
      .slots       (slots),
      .stage_wdata (stage_wdata),
      .rf_rdata    (sb.rf_rdata[p*DATA_W +: DATA_W]),
      .data        (fwd_data_a[p]),
      .sel         (fwd_sel_a[p]),
      .hazard      (hazard[p])
    );
  end

  // Flush squashes the issuing instruction, so it can neither stall nor enter.
  assign stall   = (|hazard) & sb.issue_valid & ~sb.flush;
  assign enter   = sb.issue_valid & sb.issue_we & (sb.issue_rd != REG_ZERO) & ~stall & ~sb.flush;
  assign any_fwd = |fwd_sel_a;

  assign sb.fwd_data = fwd_data_a;
  assign sb.fwd_sel  = fwd_sel_a;
  assign sb.stall    = stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots        <= '0;
      sb.stall_cnt <= '0;
      sb.fwd_cnt   <= '0;
    end else begin
      slots[0] <= '{valid: enter, rd: sb.issue_rd, load: sb.issue_load};
      for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
      if (stall && sb.stall_cnt != '1) sb.stall_cnt <= sb.stall_cnt + 1'b1;
      if (any_fwd && sb.fwd_cnt != '1) sb.fwd_cnt <= sb.fwd_cnt + 1'b1;
    end
  end
endmodule
